// File: rtl/rd_burst_master.sv
// Credit-limited read-burst master: issues sequential reads to a fixed-latency slave and buffers
// the returned words in a FIFO. Define RD_BURST_WRAP_EN to let a burst wrap past the top address.
module rd_burst_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              read,
    output logic              enable,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  cur_addr, remain;
    logic [RD_LAT-1:0]  vld_pipe;
    logic [CW-1:0]      outstanding, count;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic               zlen_q;
    logic               credit, issue, trunc, last, push, pop, accept;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Slots already promised (in flight) plus slots occupied must leave room for one more word.
    assign credit = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_W;
    assign issue  = (state == ISSUE) && credit;
    assign push   = vld_pipe[RD_LAT-1];
    assign pop    = out_valid && out_ready;
    assign accept = (state == IDLE) && start && (len != '0);

`ifdef RD_BURST_WRAP_EN
    assign trunc = 1'b0;
`else
    assign trunc = (&cur_addr) && (remain != ADDR_W'(1));
`endif
    assign last = issue && ((remain == ADDR_W'(1)) || trunc);

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (last) state_nxt = DRAIN;
            DRAIN:   if (outstanding == '0 && count == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        read      = issue;
        enable    = issue;
        addr      = cur_addr;
        busy      = (state != IDLE);
        done      = (state == DONE) || zlen_q;
        err       = zlen_q || (issue && trunc);
        out_valid = (count != '0);
        out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cur_addr    <= '0;
            remain      <= '0;
            vld_pipe    <= '0;
            outstanding <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            zlen_q      <= 1'b0;
        end else begin
            zlen_q <= (state == IDLE) && start && (len == '0);
            if (accept) begin
                cur_addr <= base_addr;
                remain   <= len;
            end else if (issue) begin
                cur_addr <= cur_addr + ADDR_W'(1);
                remain   <= remain - ADDR_W'(1);
            end
            vld_pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            case ({issue, push})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Storage needs no reset; out_data is masked while the buffer is empty.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= data;
    end

endmodule

// File: tb/tb_rd_burst_master.sv
// Bench for rd_burst_master: randomized bursts against an address-list / word-order reference model.
module tb_rd_burst_master;

    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic       clock = 0, reset_n = 0, start = 0, out_ready = 0;
    logic [7:0] base_addr = 0, len = 0;
    logic [7:0] data, addr, out_data;
    logic       read, enable, out_valid, busy, done, err;

    int total = 0, bad = 0;

    logic [7:0]        smem [256];
    logic [RD_LAT-1:0] sv = '0;
    logic [7:0]        sa [RD_LAT];

    logic [7:0] req_q[$], pop_q[$];
    int         req_cyc[$], pop_cyc[$];
    int         cyc = 0, issued = 0, popped = 0, max_if = 0;
    int         done_cnt = 0, err_cnt = 0, done_cyc = 0;
    bit         busy_seen = 0;

    rd_burst_master #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr), .len(len),
        .read(read), .enable(enable), .addr(addr), .data(data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // Fixed-latency slave: a word is only correct exactly RD_LAT edges after its request.
    always @(posedge clock) begin
        sv[0] <= read && enable;
        sa[0] <= addr;
        for (int k = 1; k < RD_LAT; k++) begin
            sv[k] <= sv[k-1];
            sa[k] <= sa[k-1];
        end
    end
    assign data = sv[RD_LAT-1] ? smem[sa[RD_LAT-1]] : ~smem[sa[RD_LAT-1]];

    always @(negedge clock) begin
        cyc++;
        if (read && enable) begin req_q.push_back(addr); req_cyc.push_back(cyc); issued++; end
        if (out_valid && out_ready) begin pop_q.push_back(out_data); pop_cyc.push_back(cyc); popped++; end
        if (issued - popped > max_if) max_if = issued - popped;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) err_cnt++;
        if (busy) busy_seen = 1;
    end

    task automatic clear_mon();
        req_q.delete(); pop_q.delete(); req_cyc.delete(); pop_cyc.delete();
        issued = 0; popped = 0; max_if = 0; done_cnt = 0; err_cnt = 0; busy_seen = 0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // mode 0: out_ready high, 1: random, 2: low for 12 cycles then high
    task automatic run_burst(input logic [7:0] b, input logic [7:0] l, input int mode, input bit stray,
                             input string nm);
        logic [7:0] exp_a[$];
        bit         trunc = 0;
        int         n;
        for (int i = 0; i < int'(l); i++) begin
`ifdef RD_BURST_WRAP_EN
            exp_a.push_back(8'(int'(b) + i));
`else
            if (int'(b) + i > 255) begin trunc = 1; break; end
            exp_a.push_back(8'(int'(b) + i));
`endif
        end
        n = exp_a.size();
        clear_mon();
        out_ready = (mode != 2);
        base_addr = b; len = l; start = 1;
        tick();
        start = 0;
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            case (mode)
                0:       out_ready = 1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (c >= 12);
            endcase
            if (stray && c == 3) begin start = 1; base_addr = b + 8'h40; len = 8'd3; end
            else start = 0;
            if (mode == 2 && c == 12) begin
                total++;
                if (issued !== DEPTH) begin
                    bad++; $display("FAIL %s stall_reqs: got %0d want %0d", nm, issued, DEPTH);
                end
            end
            tick();
        end
        start = 0; out_ready = 1;
        tick(); tick();
        total++;
        if (done_cnt !== 1) begin
            bad++; $display("FAIL %s done_count: got %0d want 1", nm, done_cnt);
        end
        total++;
        if (req_q.size() !== n) begin
            bad++; $display("FAIL %s req_count: got %0d want %0d", nm, req_q.size(), n);
        end
        for (int i = 0; i < n && i < req_q.size(); i++) begin
            total++;
            if (req_q[i] !== exp_a[i]) begin
                bad++; $display("FAIL %s addr[%0d]: got %h want %h", nm, i, req_q[i], exp_a[i]);
            end
        end
        total++;
        if (pop_q.size() !== n) begin
            bad++; $display("FAIL %s word_count: got %0d want %0d", nm, pop_q.size(), n);
        end
        for (int i = 0; i < n && i < pop_q.size(); i++) begin
            total++;
            if (pop_q[i] !== smem[exp_a[i]]) begin
                bad++; $display("FAIL %s word[%0d]: got %h want %h", nm, i, pop_q[i], smem[exp_a[i]]);
            end
        end
        total++;
        if (err_cnt !== int'(trunc)) begin
            bad++; $display("FAIL %s err_count: got %0d want %0d", nm, err_cnt, int'(trunc));
        end
        total++;
        if (max_if > DEPTH) begin
            bad++; $display("FAIL %s in_flight: got %0d want <= %0d", nm, max_if, DEPTH);
        end
        if (mode == 0 && n > 1 && req_cyc.size() == n) begin
            total++;
            if (req_cyc[n-1] - req_cyc[0] !== n - 1) begin
                bad++; $display("FAIL %s issue_span: got %0d want %0d", nm, req_cyc[n-1] - req_cyc[0], n - 1);
            end
        end
        if (pop_cyc.size() > 0 && done_cnt == 1) begin
            total++;
            if (done_cyc - pop_cyc[$] < 1 || done_cyc - pop_cyc[$] > 2) begin
                bad++; $display("FAIL %s done_delay: got %0d want 1..2", nm, done_cyc - pop_cyc[$]);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s busy_end: got %b want 0", nm, busy);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        logic [7:0] got [8];
        string      nms [8];
        got = '{8'(read), 8'(enable), addr, 8'(out_valid), 8'(busy), 8'(done), 8'(err), out_data};
        nms = '{"read", "enable", "addr", "out_valid", "busy", "done", "err", "out_data"};
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got[i] !== 8'h00) begin
                bad++; $display("FAIL %s %s: got %h want 00", nm, nms[i], got[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 0; start = 1; len = 0; base_addr = 8'h55; out_ready = 1;
        tick(); tick(); tick();
        check_idle_outputs("reset");
        start = 0; reset_n = 1;
        tick();
    endtask

    task automatic test_zero_len();
        clear_mon();
        base_addr = 8'h33; len = 0; start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        total++;
        if (err_cnt !== 1) begin bad++; $display("FAIL zero_len err_count: got %0d want 1", err_cnt); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL zero_len done_count: got %0d want 1", done_cnt); end
        total++;
        if (issued !== 0) begin bad++; $display("FAIL zero_len reqs: got %0d want 0", issued); end
        total++;
        if (busy_seen !== 1'b0) begin bad++; $display("FAIL zero_len busy: got %b want 0", busy_seen); end
    endtask

    task automatic test_mid_reset();
        clear_mon();
        out_ready = 1; base_addr = 8'h40; len = 8; start = 1;
        tick();
        start = 0;
        for (int c = 0; c < 50 && issued < 3; c++) tick();
        total++;
        if (issued < 3) begin bad++; $display("FAIL mid_reset reach_3rd: got %0d want 3", issued); end
        reset_n = 0;
        tick();
        check_idle_outputs("mid_reset");
        reset_n = 1;
        clear_mon();
        repeat (8) tick();
        total++;
        if (popped !== 0) begin bad++; $display("FAIL mid_reset stale_words: got %0d want 0", popped); end
        total++;
        if (issued !== 0) begin bad++; $display("FAIL mid_reset stray_reqs: got %0d want 0", issued); end
        run_burst(8'h70, 8'd5, 0, 0, "post_reset");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) smem[i] = 8'($urandom);
        test_reset();
        run_burst(8'h10, 8'd4, 0, 0, "basic");
        run_burst(8'h20, 8'd8, 2, 0, "backpressure");
        test_zero_len();
        run_burst(8'hFE, 8'd4, 0, 0, "wrap");
        test_mid_reset();
        run_burst(8'h80, 8'd6, 0, 1, "busy_start");
        for (int t = 0; t < 6; t++) begin
            logic [7:0] rb, rl;
            rb = 8'($urandom_range(0, 255));
            rl = 8'($urandom_range(1, 20));
            run_burst(rb, rl, t % 2, 0, "random");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rd_burst_master.md
RD_BURST_MASTER -- requirements
Module: rd_burst_master

Interface
REQ-001 Parameter ADDR_W, default 8, width of the slave address bus.
REQ-002 Parameter DATA_W, default 8, width of the slave data bus.
REQ-003 Parameter RD_LAT, default 2, fixed number of cycles from a sampled read request to valid slave data; legal range 1..4.
REQ-004 Parameter FIFO_DEPTH, default 4, depth of the return-data buffer; power of two, at least RD_LAT.
REQ-005 clock  input  1  single clock; all logic on posedge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle burst request; sampled only in IDLE.
REQ-008 base_addr  input  ADDR_W  first address of the burst.
REQ-009 len  input  ADDR_W  number of reads in the burst; 0 is illegal.
REQ-010 read  output  1  read strobe to the slave.
REQ-011 enable  output  1  transfer-valid strobe to the slave.
REQ-012 addr  output  ADDR_W  slave address.
REQ-013 data  input  DATA_W  slave read data, valid RD_LAT cycles after the request.
REQ-014 out_data  output  DATA_W  head of the return buffer.
REQ-015 out_valid  output  1  out_data is valid.
REQ-016 out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-017 busy  output  1  high outside IDLE.
REQ-018 done  output  1  one-cycle pulse when a burst completes.
REQ-019 err  output  1  one-cycle pulse on a rejected or truncated burst.

Function
REQ-020 The block SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-021 In IDLE, start with len != 0 SHALL latch base_addr and len and move to ISSUE on the next cycle.
REQ-022 In IDLE, start with len == 0 SHALL pulse err and done for one cycle and SHALL remain in IDLE.
REQ-023 In ISSUE, a request SHALL be issued only when outstanding + fifo_count < FIFO_DEPTH, where outstanding is the number of requests issued but not yet returned.
REQ-024 An issued request SHALL drive read=1, enable=1 and addr=current address for exactly one cycle.
REQ-025 After each request the address SHALL increment by 1 and the remaining count SHALL decrement by 1.
REQ-026 If the credit condition is false, read and enable SHALL be 0 and the address SHALL hold.
REQ-027 When the last request is issued, the state SHALL move to DRAIN.
REQ-028 data SHALL be written into the FIFO exactly RD_LAT cycles after each issued request, tracked by an RD_LAT-deep valid shift register.
REQ-029 A FIFO pop SHALL occur when out_valid && out_ready; a simultaneous push and pop SHALL leave the count unchanged.
REQ-030 The credit rule in REQ-023 SHALL ensure the FIFO never overflows.
REQ-031 With out_ready held at 1, the block SHALL sustain one request per cycle.
REQ-032 DRAIN SHALL move to DONE when outstanding == 0 and the FIFO is empty.
REQ-033 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-034 start SHALL be ignored while busy.
REQ-035 out_data SHALL return data in request order.

Reset
REQ-036 While reset_n == 0 at a clock edge, the state SHALL be IDLE.
REQ-037 While reset_n == 0 at a clock edge, read, enable, addr, out_valid, busy, done and err SHALL be 0.
REQ-038 While reset_n == 0 at a clock edge, the FIFO pointers and count, outstanding and the valid pipeline SHALL be cleared.
REQ-039 Reset in the middle of a burst SHALL abort it, and data returning after reset SHALL be discarded.
REQ-040 out_data SHALL be 0 after reset.

Configuration
REQ-041 With RD_BURST_WRAP_EN defined, the address SHALL wrap from 2^ADDR_W-1 to 0 and the burst SHALL continue.
REQ-042 Without RD_BURST_WRAP_EN, if the address would pass 2^ADDR_W-1, issuing SHALL stop after that address, err SHALL pulse once on the final request, and the block SHALL enter DRAIN.

Verification
REQ-043 Scenario: base 0x10, len 4, out_ready=1, RD_LAT=2 -> requests at addr 0x10..0x13 on 4 consecutive cycles; out_valid in request order; done 1 cycle after the last pop.
REQ-044 Scenario: base 0x20, len 8, out_ready=0 -> exactly 4 requests issued, then stall; raising out_ready resumes the remaining 4; all 8 words are delivered in order.
REQ-045 Scenario: start with len 0 -> err=1 and done=1 for one cycle; read and enable stay 0; busy stays 0.
REQ-046 Scenario: base 0xFE, len 4 -> with RD_BURST_WRAP_EN, addr sequence 0xFE, 0xFF, 0x00, 0x01; without it, addr sequence 0xFE, 0xFF, then err pulses and 2 words are delivered.
REQ-047 Scenario: reset_n low for 1 cycle after the 3rd request of a len-8 burst -> all outputs 0 and busy=0; no out_valid from stale returns; a new burst runs cleanly.
REQ-048 Scenario: start pulsed while busy -> ignored; the current burst's address sequence is unaffected.
